// File: rtl/p_tag_stream.sv
// Streaming Poly1305 authenticator: 256-bit one-time key, then 1-16 byte blocks, giving a 128-bit tag.
// Optional compare against a reference tag; MUL_LANES sets the 32x32 products done per MUL cycle.
//
// state | meaning
// IDLE  | waiting for i_start
// KEY   | waiting for the key beat
// BLK   | waiting for a message block
// ADD   | a = h + m, clear product accumulator
// MUL   | accumulate MUL_LANES limb products per cycle
// RED1  | first fold of the 256-bit product
// RED2  | second fold, h < 2^131
// FIN1  | conditional subtract of p
// FIN2  | add s
// OUT   | publish tag / match
module p_tag_stream #(
    parameter int MUL_LANES = 1
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic         i_empty,
    input  logic [127:0] i_tag_ref,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [255:0] i_key,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [127:0] i_blk,
    input  logic [4:0]   i_blk_bytes,
    input  logic         i_blk_last,
    output logic         o_busy,
    output logic [127:0] o_tag,
    output logic         o_tag_valid,
    output logic         o_match
);

    generate
        if (!(MUL_LANES == 1 || MUL_LANES == 2 || MUL_LANES == 4 ||
              MUL_LANES == 5 || MUL_LANES == 10 || MUL_LANES == 20)) begin : g_bad_lanes
            $error("MUL_LANES must be one of 1, 2, 4, 5, 10, 20");
        end
    endgenerate

    localparam int           MUL_CYC  = 20 / MUL_LANES;
    localparam logic [4:0]   CNT_LAST = 5'(MUL_CYC - 1);
    localparam logic [127:0] R_CLAMP  = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [130:0] P        = (131'd1 << 130) - 131'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_BLK, S_ADD, S_MUL, S_RED1, S_RED2, S_FIN1, S_FIN2, S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic          mode_q, empty_q, last_q;
    logic [127:0]  tag_ref_q, r, s;
    logic [128:0]  m_q, blk_m;
    logic [130:0]  h, fold1, fold2;
    logic [159:0]  a_q;
    logic [255:0]  acc, mul_sum;
    logic [4:0]    mul_cnt, mul_step;
    logic [4:0]    n_bytes;
    logic [127:0]  blk_masked;

    // Limb product k: limb k/4 of (h+m) times limb k%4 of r, placed at its weight.
    function automatic logic [255:0] lane_prod(input logic [159:0] a, input logic [127:0] rr,
                                               input int k);
        logic [63:0] p;
        int          i;
        int          j;
        i = k / 4;
        j = k % 4;
        p = 64'(a[32*i +: 32]) * 64'(rr[32*j +: 32]);
        return 256'(p) << (32 * (i + j));
    endfunction

    always_comb begin
        n_bytes    = (i_blk_bytes == 5'd0 || i_blk_bytes >= 5'd16) ? 5'd16 : i_blk_bytes;
        blk_masked = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < int'(n_bytes)) blk_masked[8*b +: 8] = i_blk[8*b +: 8];
        end
        blk_m = {1'b0, blk_masked} | (129'd1 << {n_bytes, 3'b000});
    end

    assign mul_step = CNT_LAST - mul_cnt;

    always_comb begin
        mul_sum = acc;
        for (int l = 0; l < MUL_LANES; l++) begin
            mul_sum = mul_sum + lane_prod(a_q, r, int'(mul_step) * MUL_LANES + l);
        end
    end

    // 2^130 == 5 (mod p)
    assign fold1 = 131'(acc[129:0]) + 131'(acc[255:130]) * 131'd5;
    assign fold2 = 131'(h[129:0]) + 131'(h[130]) * 131'd5;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (i_start)     state_nxt = S_KEY;
            S_KEY:  if (i_key_valid) state_nxt = empty_q ? S_FIN1 : S_BLK;
            S_BLK:  if (i_blk_valid) state_nxt = S_ADD;
            S_ADD:  state_nxt = S_MUL;
            S_MUL:  if (mul_cnt == 5'd0) state_nxt = S_RED1;
            S_RED1: state_nxt = S_RED2;
            S_RED2: state_nxt = last_q ? S_FIN1 : S_BLK;
            S_FIN1: state_nxt = S_FIN2;
            S_FIN2: state_nxt = S_OUT;
            S_OUT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_key_ready = (state == S_KEY);
    assign o_blk_ready = (state == S_BLK);
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q      <= 1'b0;
            empty_q     <= 1'b0;
            last_q      <= 1'b0;
            tag_ref_q   <= '0;
            r           <= '0;
            s           <= '0;
            m_q         <= '0;
            h           <= '0;
            a_q         <= '0;
            acc         <= '0;
            mul_cnt     <= '0;
            o_tag       <= '0;
            o_tag_valid <= 1'b0;
            o_match     <= 1'b0;
        end else begin
            o_tag_valid <= 1'b0;
            unique case (state)
                S_IDLE: if (i_start) begin
                    mode_q    <= i_mode;
                    empty_q   <= i_empty;
                    tag_ref_q <= i_tag_ref;
                    h         <= '0;
                end
                S_KEY: if (i_key_valid) begin
                    r <= i_key[127:0] & R_CLAMP;
                    s <= i_key[255:128];
                end
                S_BLK: if (i_blk_valid) begin
                    m_q    <= blk_m;
                    last_q <= i_blk_last;
                end
                S_ADD: begin
                    a_q     <= 160'(h) + 160'(m_q);
                    acc     <= '0;
                    mul_cnt <= CNT_LAST;
                end
                S_MUL: begin
                    acc <= mul_sum;
                    if (mul_cnt != 5'd0) mul_cnt <= mul_cnt - 5'd1;
                end
                S_RED1: h <= fold1;
                S_RED2: h <= fold2;
                S_FIN1: if (h >= P) h <= h - P;
                S_FIN2: h <= {3'b000, h[127:0] + s};
                S_OUT: begin
                    o_tag       <= h[127:0];
                    o_match     <= mode_q && (h[127:0] == tag_ref_q);
                    o_tag_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p_tag_stream.sv
// Directed bench for p_tag_stream: RFC 8439 Poly1305 vector on MUL_LANES = 1 and 20 instances,
// a vector table of run variants plus hand sequences for mid-run reset and ignored i_start.
module tb_p_tag_stream;

    localparam logic [127:0] R_LE  = 128'ha806d542_fe52447f_336d5557_78bed685;
    localparam logic [127:0] S_LE  = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301;
    localparam logic [127:0] T_LE  = 128'ha927010c_af8b2bc2_c6365130_c11d06a8;
    localparam logic [255:0] KEY   = {S_LE, R_LE};

    logic         clk;
    logic         rstn;
    logic [1:0]   start, mode, empty_i, key_valid, blk_valid, blk_last;
    logic [127:0] tag_ref [2];
    logic [255:0] key_d   [2];
    logic [127:0] blk     [2];
    logic [4:0]   blk_bytes [2];
    wire  [1:0]   key_ready, blk_ready, busy, tag_valid, match;
    wire  [127:0] tag0, tag1;

    int    n_chk;
    int    n_fail;
    int    cyc;
    string msg = "Cryptographic Forum Research Group";

    p_tag_stream #(.MUL_LANES(1)) dut_l1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start[0]), .i_mode(mode[0]), .i_empty(empty_i[0]),
        .i_tag_ref(tag_ref[0]), .i_key_valid(key_valid[0]), .o_key_ready(key_ready[0]),
        .i_key(key_d[0]), .i_blk_valid(blk_valid[0]), .o_blk_ready(blk_ready[0]), .i_blk(blk[0]),
        .i_blk_bytes(blk_bytes[0]), .i_blk_last(blk_last[0]), .o_busy(busy[0]), .o_tag(tag0),
        .o_tag_valid(tag_valid[0]), .o_match(match[0])
    );

    p_tag_stream #(.MUL_LANES(20)) dut_l20 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start[1]), .i_mode(mode[1]), .i_empty(empty_i[1]),
        .i_tag_ref(tag_ref[1]), .i_key_valid(key_valid[1]), .o_key_ready(key_ready[1]),
        .i_key(key_d[1]), .i_blk_valid(blk_valid[1]), .o_blk_ready(blk_ready[1]), .i_blk(blk[1]),
        .i_blk_bytes(blk_bytes[1]), .i_blk_last(blk_last[1]), .o_busy(busy[1]), .o_tag(tag1),
        .o_tag_valid(tag_valid[1]), .o_match(match[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int           d;
        bit           vmode;
        bit           vempty;
        logic [127:0] ref_tag;
        logic [7:0]   fill;
        bit           zero_full;
        bit           gap;
        int           key_dly;
        logic [127:0] exp_tag;
        bit           exp_match;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [127:0] get_tag(input int d);
        return (d == 0) ? tag0 : tag1;
    endfunction

    function automatic logic sig(input int d, input int which);
        case (which)
            0:       return blk_ready[d];
            1:       return tag_valid[d];
            default: return key_ready[d];
        endcase
    endfunction

    function automatic logic [127:0] blk_of(input int b, input logic [7:0] fill);
        logic [127:0] v;
        int           idx;
        for (int i = 0; i < 16; i++) begin
            idx = 16 * b + i;
            v[8*i +: 8] = (idx < msg.len()) ? msg[idx] : fill;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Polls at negedges; the delta is counted in clock edges since the handshake edge.
    task automatic wait_for(input int d, input int which, input int hs, input int exp_delta,
                            input string name);
        int n;
        n = 0;
        while (!sig(d, which) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sig(d, which)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end else begin
            check(name, 128'(cyc - hs), 128'(exp_delta));
        end
    endtask

    task automatic do_start(input int d, input bit m, input bit e, input logic [127:0] rt,
                            input string name);
        @(negedge clk);
        check({name, "_idle_before"}, 128'(busy[d]), 128'(0));
        start[d] = 1'b1; mode[d] = m; empty_i[d] = e; tag_ref[d] = rt;
        @(negedge clk);
        start[d] = 1'b0; mode[d] = 1'b0; empty_i[d] = 1'b0; tag_ref[d] = '0;
        check({name, "_busy_rise"}, 128'(busy[d]), 128'(1));
        check({name, "_key_ready"}, 128'(key_ready[d]), 128'(1));
    endtask

    task automatic do_key(input int d, input int dly, output int hs);
        int n;
        repeat (dly) @(negedge clk);
        key_valid[d] = 1'b1;
        key_d[d]     = KEY;
        n = 0;
        while (!key_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        hs = cyc;
        key_valid[d] = 1'b0;
        key_d[d]     = '0;
    endtask

    task automatic do_blk(input int d, input logic [127:0] data, input logic [4:0] nb,
                          input bit last, output int hs);
        int n;
        blk_valid[d] = 1'b1; blk[d] = data; blk_bytes[d] = nb; blk_last[d] = last;
        n = 0;
        while (!blk_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        hs = cyc;
        blk_valid[d] = 1'b0; blk[d] = '0; blk_bytes[d] = '0; blk_last[d] = 1'b0;
    endtask

    task automatic feed(input vec_t v, input int hs_key, input string name);
        int           hs;
        int           n_mul;
        logic [127:0] data;
        n_mul = (v.d == 0) ? 20 : 1;
        if (v.vempty) begin
            wait_for(v.d, 1, hs_key, 3, {name, "_empty_lat"});
        end else begin
            for (int b = 0; b < 3; b++) begin
                data = blk_of(b, v.fill);
                do_blk(v.d, data, (b < 2) ? (v.zero_full ? 5'd0 : 5'd16) : 5'd2, b == 2, hs);
                if (b < 2) begin
                    wait_for(v.d, 0, hs, 3 + n_mul, {name, "_blk_spacing"});
                    if (v.gap) repeat ($urandom_range(1, 6)) @(negedge clk);
                end else begin
                    wait_for(v.d, 1, hs, 6 + n_mul, {name, "_tag_lat"});
                end
            end
        end
        check({name, "_tag"}, get_tag(v.d), v.exp_tag);
        check({name, "_match"}, 128'(match[v.d]), 128'(v.exp_match));
        check({name, "_busy_low"}, 128'(busy[v.d]), 128'(0));
        @(negedge clk);
        check({name, "_pulse_end"}, 128'(tag_valid[v.d]), 128'(0));
        check({name, "_tag_hold"}, get_tag(v.d), v.exp_tag);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int hs;
        do_start(v.d, v.vmode, v.vempty, v.ref_tag, name);
        do_key(v.d, v.key_dly, hs);
        feed(v, hs, name);
    endtask

    initial begin
        int   hs;
        vec_t v;
        rstn = 1'b0;
        start = '0; mode = '0; empty_i = '0; key_valid = '0; blk_valid = '0; blk_last = '0;
        for (int d = 0; d < 2; d++) begin
            tag_ref[d] = '0; key_d[d] = '0; blk[d] = '0; blk_bytes[d] = '0;
        end

        //            d  mode empty ref        fill   zf gap kd exp_tag  match
        vecs[0] = '{0, 0, 0, '0,          8'h00, 0, 0, 0, T_LE, 0};
        vecs[1] = '{1, 0, 0, '0,          8'h00, 0, 0, 0, T_LE, 0};
        vecs[2] = '{0, 1, 0, T_LE,        8'h00, 0, 0, 0, T_LE, 1};
        vecs[3] = '{1, 1, 0, T_LE ^ 128'd1, 8'h00, 0, 0, 0, T_LE, 0};
        vecs[4] = '{1, 0, 0, '0,          8'hff, 0, 0, 0, T_LE, 0};
        vecs[5] = '{0, 0, 1, '0,          8'h00, 0, 0, 0, S_LE, 0};
        vecs[6] = '{1, 1, 1, S_LE,        8'h00, 0, 0, 0, S_LE, 1};
        vecs[7] = '{1, 0, 0, '0,          8'h00, 1, 0, 0, T_LE, 0};
        vecs[8] = '{0, 0, 0, '0,          8'hff, 0, 1, 5, T_LE, 0};
        vecs[9] = '{1, 1, 0, T_LE,        8'h00, 1, 1, 5, T_LE, 1};

        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_busy%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("reset_key_ready%0d", d), 128'(key_ready[d]), 128'(0));
            check($sformatf("reset_tag_valid%0d", d), 128'(tag_valid[d]), 128'(0));
            check($sformatf("reset_match%0d", d), 128'(match[d]), 128'(0));
        end
        check("reset_tag0", tag0, '0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during MUL of block 2 on the 1-lane instance.
        do_start(0, 1'b0, 1'b0, '0, "rst");
        do_key(0, 0, hs);
        do_blk(0, blk_of(0, 8'h00), 5'd16, 1'b0, hs);
        wait_for(0, 0, hs, 23, "rst_blk1_spacing");
        do_blk(0, blk_of(1, 8'h00), 5'd16, 1'b0, hs);
        repeat (6) @(negedge clk);
        check("rst_busy_before", 128'(busy[0]), 128'(1));
        #2 rstn = 1'b0;
        #1;
        check("rst_busy", 128'(busy[0]), 128'(0));
        check("rst_key_ready", 128'(key_ready[0]), 128'(0));
        check("rst_blk_ready", 128'(blk_ready[0]), 128'(0));
        check("rst_tag", tag0, '0);
        check("rst_tag_valid", 128'(tag_valid[0]), 128'(0));
        check("rst_match", 128'(match[0]), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        run_vec(vecs[0], "after_rst");

        // i_start with verify mode while in BLK must not touch the sampled run settings.
        v = vecs[1];
        do_start(1, 1'b0, 1'b0, T_LE, "ign");
        do_key(1, 0, hs);
        check("ign_in_blk", 128'(blk_ready[1]), 128'(1));
        start[1] = 1'b1; mode[1] = 1'b1; empty_i[1] = 1'b1; tag_ref[1] = T_LE;
        @(negedge clk);
        start[1] = 1'b0; mode[1] = 1'b0; empty_i[1] = 1'b0; tag_ref[1] = '0;
        feed(v, hs, "ign");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/p_tag_stream.md
# p_tag_stream

Parametrised, streaming Poly1305 one-time authenticator and successor to the fixed-latency tag block. It accepts a 256-bit one-time key and then a stream of 1–16-byte message blocks over valid/ready handshakes. It produces the 128-bit tag and can also compare the result against a reference tag. Multiplier parallelism is set at elaboration, so area/latency trades across the ChaCha20-Poly1305 AEAD top.

## Interface
- MUL_LANES, 1, 32x32 partial products per cycle; legal values 1, 2, 4, 5, 10, 20. Other values are an elaboration error.
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_start  in  1  starts a run. Accepted only in IDLE; ignored otherwise.
- i_mode  in  1  sampled with accepted i_start. 0 = generate, 1 = verify.
- i_empty  in  1  sampled with accepted i_start. 1 = zero-length message.
- i_tag_ref  in  128  reference tag, sampled with accepted i_start.
- i_key_valid  in  1  key beat valid.
- o_key_ready  out  1  high only in KEY.
- i_key  in  256  [127:0] = r, [255:128] = s. Little-endian: [7:0] is key byte 0.
- i_blk_valid  in  1  message block valid.
- o_blk_ready  out  1  high only in BLK.
- i_blk  in  128  block, little-endian. Bytes at or above i_blk_bytes are ignored.
- i_blk_bytes  in  5  valid byte count. 1–15 = partial; 0 or ≥16 = full block.
- i_blk_last  in  1  marks the final block.
- o_busy  out  1  high in every state except IDLE.
- o_tag  out  128  last computed tag, little-endian. Held until the next completion.
- o_tag_valid  out  1  one-cycle pulse when o_tag/o_match update.
- o_match  out  1  verify mode: o_tag == tag_ref. Always 0 in generate mode. Held with o_tag.

## Operation
- p = 2^130 − 5.
- Accumulator h: 131-bit, partially reduced. Cleared on accepted i_start.
- Key handshake: r ← i_key[127:0] & 0x0ffffffc_0ffffffc_0ffffffc_0fffffff; s ← i_key[255:128].
- Block value: n = i_blk_bytes (0/≥16 → 16). m = (i_blk masked to low n bytes) + 2^(8n).
- Per block: h ← ((h + m) · r) reduced.
  - The product is < 2^256. It is computed as 20 limb products (5 limbs of h+m × 4 limbs of r), accumulated MUL_LANES per cycle.
- Reduction is two folds of x ← x[129:0] + 5·(x >> 130), giving h < 2^131.
- Finalise:
  - h ← h − p if h ≥ p. A single conditional subtract is sufficient.
  - tag = (h + s) mod 2^128.
- States:
  - IDLE → KEY on i_start.
  - KEY → BLK on key handshake, or → FIN1 if the sampled i_empty = 1.
  - BLK → ADD on block handshake. i_blk_last is latched at the handshake.
  - ADD (1 cycle) → MUL.
  - MUL (20/MUL_LANES cycles) → RED1 → RED2.
  - RED2 → FIN1 if the latched last = 1, else → BLK.
  - FIN1 (conditional subtract) → FIN2 (add s) → OUT → IDLE.
- OUT: o_tag, o_match and o_tag_valid are updated. o_match = (i_mode && tag == tag_ref).
- Empty message: tag = s.
- i_key_valid outside KEY and i_blk_valid outside BLK are ignored. No data is consumed.
- Reset, including mid-run: state → IDLE; h, r, s, all latches → 0; every output → 0 (o_key_ready, o_blk_ready, o_busy, o_tag, o_tag_valid, o_match).

## Timing
- o_busy rises the cycle after accepted i_start. KEY is entered that cycle, so o_key_ready is high one cycle after i_start.
- Block throughput: from the block handshake edge to o_blk_ready high again is 3 + 20/MUL_LANES cycles, plus any cycles spent waiting for i_blk_valid.
  - MUL_LANES = 1 → 23 cycles; MUL_LANES = 20 → 4 cycles.
- Last block handshake → o_tag_valid pulse = 3 + 20/MUL_LANES + 3 cycles (RED2 → FIN1 → FIN2 → OUT).
- Empty message: key handshake → o_tag_valid = 3 cycles.
- o_busy falls the cycle after OUT. A new i_start is accepted in that same IDLE cycle.
- Ready signals are registered state decodes. They do not depend combinationally on valid.
- i_start asserted while o_busy = 1 has no effect, including on the sampled mode, empty and tag_ref.

## Test plan
- RFC 8439 §2.5.2, MUL_LANES = 1 and 20, generate mode.
  - Stimulus: key r = 85d6be7857556d337f4452fe42d506a8, s = 0103808afb0db2fd4abff6af4149f51b (byte order); message "Cryptographic Forum Research Group" as blocks of 16, 16 and 2 bytes.
  - Required: tag bytes a8061dc130 5136c6c22b8baf0c0127a9. Block-to-ready spacing 23 and 4 cycles respectively.
- Empty message: i_empty = 1, same key → o_tag = s bytes 01 03 80 8a … f5 1b; o_tag_valid 3 cycles after the key handshake.
- Verify mode, RFC vector:
  - i_tag_ref = correct tag → o_match = 1.
  - i_tag_ref with bit 0 flipped → o_match = 0; o_tag still equals the correct tag.
- Partial-block masking: the RFC run with the last block's upper 14 bytes = 0xFF → identical tag to the zero-filled run.
- Reset asserted during MUL of block 2:
  - All outputs read 0 immediately.
  - A subsequent full RFC run yields the correct tag.
- Flow control:
  - i_blk_valid gapped randomly and i_key_valid delayed 5 cycles → same tag.
  - i_start pulsed during BLK with i_mode = 1 → ignored, o_match = 0 at the end.
  - Block presented with i_blk_bytes = 0 → treated as 16 bytes.
